// File: rtl/mpc_fabric_pkg.sv
// rtl/mpc_fabric_pkg.sv - shared types and constants for the CAN port AXI-Lite fabric
package mpc_fabric_pkg;

  typedef enum logic [2:0] {
    IDLE,
    W_REQ,
    W_WAIT,
    W_RESP,
    R_REQ,
    R_WAIT,
    R_RESP
  } state_e;

  localparam logic [1:0]  RESP_OKAY     = 2'b00;
  localparam logic [1:0]  RESP_SLVERR   = 2'b10;
  localparam logic [1:0]  RESP_DECERR   = 2'b11;

  localparam logic [31:0] TIMEOUT_RDATA = 32'hFFFF_FFFF;

  // Port index field width: enough for the largest supported port count.
  localparam int          PORT_IDX_W    = 4;
  localparam int          TIMER_W       = 16;

endpackage

// File: rtl/mpc_fabric_timer.sv
// rtl/mpc_fabric_timer.sv - downstream response timer with clear/enable/limit and expiry flag
module mpc_fabric_timer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             enable_i,
  input  logic [WIDTH-1:0] limit_i,
  output logic             expired_o
);

  logic [WIDTH-1:0] count_q;

  // Expiry is only meaningful while the timer is counting a live transaction.
  assign expired_o = enable_i && (count_q == limit_i);

  // Count cycles spent waiting on the downstream port; hold once the limit is hit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clear_i) begin
      count_q <= '0;
    end else if (enable_i && !expired_o) begin
      count_q <= count_q + 1'b1;
    end
  end

endmodule

// File: rtl/mpc_axil_fabric.sv
// rtl/mpc_axil_fabric.sv - AXI-Lite decode fabric to per-port CAN buses (optional timeout: MPC_FABRIC_TIMEOUT_EN)
module mpc_axil_fabric
  import mpc_fabric_pkg::*;
#(
  parameter int PORT_NUM       = 4,
  parameter int PORT_ADDR_BITS = 12,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                               aclk,
  input  logic                               aresetn,
  // upstream write address / data / response
  input  logic                               s_awvalid,
  output logic                               s_awready,
  input  logic [31:0]                        s_awaddr,
  input  logic                               s_wvalid,
  output logic                               s_wready,
  input  logic [31:0]                        s_wdata,
  input  logic [3:0]                         s_wstrb,
  output logic                               s_bvalid,
  input  logic                               s_bready,
  output logic [1:0]                         s_bresp,
  // upstream read address / data
  input  logic                               s_arvalid,
  output logic                               s_arready,
  input  logic [31:0]                        s_araddr,
  input  logic [3:0]                         s_aruser,
  output logic                               s_rvalid,
  input  logic                               s_rready,
  output logic [31:0]                        s_rdata,
  output logic [1:0]                         s_rresp,
  // downstream, one slice per port
  output logic [PORT_NUM-1:0]                m_awvalid,
  input  logic [PORT_NUM-1:0]                m_awready,
  output logic [PORT_NUM*PORT_ADDR_BITS-1:0] m_awaddr,
  output logic [PORT_NUM-1:0]                m_wvalid,
  input  logic [PORT_NUM-1:0]                m_wready,
  output logic [PORT_NUM*32-1:0]             m_wdata,
  output logic [PORT_NUM*4-1:0]              m_wstrb,
  input  logic [PORT_NUM-1:0]                m_bvalid,
  output logic [PORT_NUM-1:0]                m_bready,
  input  logic [PORT_NUM*2-1:0]              m_bresp,
  output logic [PORT_NUM-1:0]                m_arvalid,
  input  logic [PORT_NUM-1:0]                m_arready,
  output logic [PORT_NUM*PORT_ADDR_BITS-1:0] m_araddr,
  output logic [PORT_NUM*4-1:0]              m_aruser,
  input  logic [PORT_NUM-1:0]                m_rvalid,
  output logic [PORT_NUM-1:0]                m_rready,
  input  logic [PORT_NUM*32-1:0]             m_rdata,
  input  logic [PORT_NUM*2-1:0]              m_rresp,
  // interrupts
  input  logic [PORT_NUM-1:0]                intr_i,
  output logic                               intr_request
);

  state_e                    state_q, state_d;
  logic                      last_rd_q, last_rd_d;
  logic [PORT_ADDR_BITS-1:0] addr_q, addr_d;
  logic [31:0]               wdata_q, wdata_d;
  logic [3:0]                wstrb_q, wstrb_d;
  logic [3:0]                aruser_q, aruser_d;
  logic [PORT_IDX_W-1:0]     port_q, port_d;
  logic                      aw_done_q, aw_done_d;
  logic                      w_done_q, w_done_d;
  logic [1:0]                resp_q, resp_d;
  logic [31:0]               rdata_q, rdata_d;
  logic                      intr_q;

  logic                      timer_expired;

  logic [31:0]               aw_idx, ar_idx;
  logic                      aw_decerr, ar_decerr;
  logic                      wr_pend, rd_pend, grant_w, grant_r;

  logic                      aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic [1:0]                bresp_sel, rresp_sel;
  logic [31:0]               rdata_sel;

  // Any address whose window index lands past the last port is a decode error,
  // which also covers nonzero address bits above the index field.
  assign aw_idx    = s_awaddr >> PORT_ADDR_BITS;
  assign ar_idx    = s_araddr >> PORT_ADDR_BITS;
  assign aw_decerr = (aw_idx >= 32'(PORT_NUM));
  assign ar_decerr = (ar_idx >= 32'(PORT_NUM));

  // Alternate between directions when both are pending; a lone request always wins.
  assign wr_pend   = s_awvalid && s_wvalid;
  assign rd_pend   = s_arvalid;
  assign grant_w   = (state_q == IDLE) && wr_pend && (!rd_pend || last_rd_q);
  assign grant_r   = (state_q == IDLE) && rd_pend && !grant_w;

  assign s_awready = grant_w;
  assign s_wready  = grant_w;
  assign s_arready = grant_r;

  assign s_bvalid  = (state_q == W_RESP);
  assign s_bresp   = s_bvalid ? resp_q : 2'b00;
  assign s_rvalid  = (state_q == R_RESP);
  assign s_rresp   = s_rvalid ? resp_q : 2'b00;
  assign s_rdata   = s_rvalid ? rdata_q : 32'h0;

  assign intr_request = intr_q;

  // Fan the single outstanding transaction out to the selected port slice and
  // collapse that slice's handshakes back into scalars.
  always_comb begin
    m_awvalid = '0;
    m_awaddr  = '0;
    m_wvalid  = '0;
    m_wdata   = '0;
    m_wstrb   = '0;
    m_bready  = '0;
    m_arvalid = '0;
    m_araddr  = '0;
    m_aruser  = '0;
    m_rready  = '0;
    aw_hs     = 1'b0;
    w_hs      = 1'b0;
    b_hs      = 1'b0;
    ar_hs     = 1'b0;
    r_hs      = 1'b0;
    bresp_sel = 2'b00;
    rresp_sel = 2'b00;
    rdata_sel = 32'h0;
    for (int p = 0; p < PORT_NUM; p++) begin
      if (port_q == PORT_IDX_W'(p) && !timer_expired) begin
        if (state_q == W_REQ) begin
          m_awvalid[p]                                 = !aw_done_q;
          m_wvalid[p]                                  = !w_done_q;
          m_awaddr[p*PORT_ADDR_BITS +: PORT_ADDR_BITS] = addr_q;
          m_wdata[p*32 +: 32]                          = wdata_q;
          m_wstrb[p*4 +: 4]                            = wstrb_q;
        end
        m_bready[p] = (state_q == W_WAIT);
        if (state_q == R_REQ) begin
          m_arvalid[p]                                 = 1'b1;
          m_araddr[p*PORT_ADDR_BITS +: PORT_ADDR_BITS] = addr_q;
          m_aruser[p*4 +: 4]                           = aruser_q;
        end
        m_rready[p] = (state_q == R_WAIT);
        aw_hs     = m_awvalid[p] && m_awready[p];
        w_hs      = m_wvalid[p] && m_wready[p];
        b_hs      = m_bready[p] && m_bvalid[p];
        ar_hs     = m_arvalid[p] && m_arready[p];
        r_hs      = m_rready[p] && m_rvalid[p];
        bresp_sel = m_bresp[p*2 +: 2];
        rresp_sel = m_rresp[p*2 +: 2];
        rdata_sel = m_rdata[p*32 +: 32];
      end
    end
  end

  // Transaction sequencing: accept, downstream request, wait, upstream response.
  always_comb begin
    state_d   = state_q;
    last_rd_d = last_rd_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    aruser_d  = aruser_q;
    port_d    = port_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    resp_d    = resp_q;
    rdata_d   = rdata_q;
    case (state_q)
      IDLE: begin
        if (grant_w) begin
          last_rd_d = 1'b0;
          addr_d    = s_awaddr[PORT_ADDR_BITS-1:0];
          wdata_d   = s_wdata;
          wstrb_d   = s_wstrb;
          port_d    = aw_idx[PORT_IDX_W-1:0];
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          if (aw_decerr) begin
            resp_d  = RESP_DECERR;
            state_d = W_RESP;
          end else begin
            state_d = W_REQ;
          end
        end else if (grant_r) begin
          last_rd_d = 1'b1;
          addr_d    = s_araddr[PORT_ADDR_BITS-1:0];
          aruser_d  = s_aruser;
          port_d    = ar_idx[PORT_IDX_W-1:0];
          if (ar_decerr) begin
            resp_d  = RESP_DECERR;
            rdata_d = 32'h0;
            state_d = R_RESP;
          end else begin
            state_d = R_REQ;
          end
        end
      end
      W_REQ: begin
        if (timer_expired) begin
          resp_d  = RESP_SLVERR;
          state_d = W_RESP;
        end else begin
          aw_done_d = aw_done_q || aw_hs;
          w_done_d  = w_done_q || w_hs;
          if (aw_done_d && w_done_d) begin
            state_d = W_WAIT;
          end
        end
      end
      W_WAIT: begin
        if (timer_expired) begin
          resp_d  = RESP_SLVERR;
          state_d = W_RESP;
        end else if (b_hs) begin
          resp_d  = bresp_sel;
          state_d = W_RESP;
        end
      end
      W_RESP: begin
        if (s_bready) begin
          state_d = IDLE;
        end
      end
      R_REQ: begin
        if (timer_expired) begin
          resp_d  = RESP_SLVERR;
          rdata_d = TIMEOUT_RDATA;
          state_d = R_RESP;
        end else if (ar_hs) begin
          state_d = R_WAIT;
        end
      end
      R_WAIT: begin
        if (timer_expired) begin
          resp_d  = RESP_SLVERR;
          rdata_d = TIMEOUT_RDATA;
          state_d = R_RESP;
        end else if (r_hs) begin
          resp_d  = rresp_sel;
          rdata_d = rdata_sel;
          state_d = R_RESP;
        end
      end
      R_RESP: begin
        if (s_rready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and captured-transaction registers; reset abandons any transaction in flight.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= IDLE;
      last_rd_q <= 1'b1;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      aruser_q  <= '0;
      port_q    <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      resp_q    <= RESP_OKAY;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      last_rd_q <= last_rd_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      aruser_q  <= aruser_d;
      port_q    <= port_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      resp_q    <= resp_d;
      rdata_q   <= rdata_d;
    end
  end

  // Combined interrupt request, registered once.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      intr_q <= 1'b0;
    end else begin
      intr_q <= |intr_i;
    end
  end

`ifdef MPC_FABRIC_TIMEOUT_EN
  logic timer_clear;
  logic timer_en;

  assign timer_clear = (state_q == IDLE) && ((state_d == W_REQ) || (state_d == R_REQ));
  assign timer_en    = (state_q == W_REQ) || (state_q == W_WAIT) ||
                       (state_q == R_REQ) || (state_q == R_WAIT);

  mpc_fabric_timer #(
    .WIDTH (TIMER_W)
  ) u_timer (
    .clk       (aclk),
    .rst_n     (aresetn),
    .clear_i   (timer_clear),
    .enable_i  (timer_en),
    .limit_i   (TIMER_W'(TIMEOUT_CYCLES)),
    .expired_o (timer_expired)
  );
`else
  // Without the timer a stalled port holds the fabric indefinitely; only a
  // degenerate zero budget would ever count as expired.
  assign timer_expired = (TIMEOUT_CYCLES == 0);
`endif

endmodule

// File: tb/tb_mpc_axil_fabric.sv
// tb/tb_mpc_axil_fabric.sv - scoreboard bench for the CAN port AXI-Lite fabric
module tb_mpc_axil_fabric;

  localparam int NP  = 4;
  localparam int PAB = 12;

  typedef struct {
    bit          is_rd;
    logic [1:0]  resp;
    logic [31:0] data;
  } exp_t;

  logic aclk = 1'b0;
  logic aresetn;

  logic s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic s_arvalid, s_arready, s_rvalid, s_rready;
  logic [31:0] s_awaddr, s_wdata, s_araddr, s_rdata;
  logic [3:0]  s_wstrb, s_aruser;
  logic [1:0]  s_bresp, s_rresp;

  logic [NP-1:0]     m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic [NP-1:0]     m_arvalid, m_arready, m_rvalid, m_rready;
  logic [NP*PAB-1:0] m_awaddr, m_araddr;
  logic [NP*32-1:0]  m_wdata, m_rdata;
  logic [NP*4-1:0]   m_wstrb, m_aruser;
  logic [NP*2-1:0]   m_bresp, m_rresp;
  logic [NP-1:0]     intr_i;
  logic              intr_request;

  logic [NP-1:0] port_en;
  logic [NP-1:0] rd_hold;
  logic [31:0]   rd_val [NP];
  logic [1:0]    b_val  [NP];
  logic [PAB-1:0] port_wr_addr [NP];
  logic [31:0]   port_wr_data [NP];

  exp_t sb_q[$];
  exp_t mon_e;
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  int            lat;
  int            arv_cycles;
  logic [NP-1:0] snap_awv, snap_arv;
  logic [NP*PAB-1:0] snap_awaddr, snap_araddr;
  logic [NP*32-1:0]  snap_wdata;
  logic [NP*4-1:0]   snap_wstrb, snap_aruser;

  assign m_awready = port_en;
  assign m_wready  = port_en;
  assign m_arready = port_en;

  always #5 aclk = ~aclk;

  mpc_axil_fabric #(
    .PORT_NUM       (NP),
    .PORT_ADDR_BITS (PAB),
    .TIMEOUT_CYCLES (10)
  ) dut (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .s_awvalid    (s_awvalid),
    .s_awready    (s_awready),
    .s_awaddr     (s_awaddr),
    .s_wvalid     (s_wvalid),
    .s_wready     (s_wready),
    .s_wdata      (s_wdata),
    .s_wstrb      (s_wstrb),
    .s_bvalid     (s_bvalid),
    .s_bready     (s_bready),
    .s_bresp      (s_bresp),
    .s_arvalid    (s_arvalid),
    .s_arready    (s_arready),
    .s_araddr     (s_araddr),
    .s_aruser     (s_aruser),
    .s_rvalid     (s_rvalid),
    .s_rready     (s_rready),
    .s_rdata      (s_rdata),
    .s_rresp      (s_rresp),
    .m_awvalid    (m_awvalid),
    .m_awready    (m_awready),
    .m_awaddr     (m_awaddr),
    .m_wvalid     (m_wvalid),
    .m_wready     (m_wready),
    .m_wdata      (m_wdata),
    .m_wstrb      (m_wstrb),
    .m_bvalid     (m_bvalid),
    .m_bready     (m_bready),
    .m_bresp      (m_bresp),
    .m_arvalid    (m_arvalid),
    .m_arready    (m_arready),
    .m_araddr     (m_araddr),
    .m_aruser     (m_aruser),
    .m_rvalid     (m_rvalid),
    .m_rready     (m_rready),
    .m_rdata      (m_rdata),
    .m_rresp      (m_rresp),
    .intr_i       (intr_i),
    .intr_request (intr_request)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: actual %0h required %0h", name, act, req);
  endtask

  task automatic push(input bit rd, input logic [1:0] r, input logic [31:0] d);
    exp_t e;
    e.is_rd = rd;
    e.resp  = r;
    e.data  = d;
    sb_q.push_back(e);
  endtask

  // Monitor: every upstream response handshake is checked against the queue head.
  always @(negedge aclk) begin
    if (aresetn && ((s_bvalid && s_bready) || (s_rvalid && s_rready))) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_resp", 1'b1, 1'b0);
      end else begin
        mon_e = sb_q.pop_front();
        chk("sb_kind", s_rvalid, mon_e.is_rd);
        chk("sb_resp", s_rvalid ? s_rresp : s_bresp, mon_e.resp);
        if (mon_e.is_rd) chk("sb_rdata", s_rdata, mon_e.data);
      end
    end
  end

  // Downstream port model: zero-wait ready, response one cycle after the request.
  initial begin
    logic [NP-1:0] ar_seen, aw_seen, w_seen, r_fire, b_fire, aw_got, w_got;
    m_bvalid = '0; m_bresp = '0; m_rvalid = '0; m_rdata = '0; m_rresp = '0;
    aw_got = '0; w_got = '0;
    forever begin
      @(negedge aclk);
      ar_seen = m_arvalid & m_arready;
      aw_seen = m_awvalid & m_awready;
      w_seen  = m_wvalid & m_wready;
      r_fire  = m_rvalid & m_rready;
      b_fire  = m_bvalid & m_bready;
      for (int p = 0; p < NP; p++) begin
        if (aw_seen[p]) port_wr_addr[p] = m_awaddr[p*PAB +: PAB];
        if (w_seen[p])  port_wr_data[p] = m_wdata[p*32 +: 32];
      end
      @(posedge aclk); #1;
      if (!aresetn) begin
        m_bvalid = '0; m_rvalid = '0; aw_got = '0; w_got = '0;
      end else begin
        for (int p = 0; p < NP; p++) begin
          if (r_fire[p]) m_rvalid[p] = 1'b0;
          if (ar_seen[p] && !rd_hold[p]) begin
            m_rvalid[p]          = 1'b1;
            m_rdata[p*32 +: 32]  = rd_val[p];
            m_rresp[p*2 +: 2]    = 2'b00;
          end
          if (b_fire[p]) m_bvalid[p] = 1'b0;
          aw_got[p] = aw_got[p] | aw_seen[p];
          w_got[p]  = w_got[p] | w_seen[p];
          if (aw_got[p] && w_got[p]) begin
            m_bvalid[p]        = 1'b1;
            m_bresp[p*2 +: 2]  = b_val[p];
            aw_got[p]          = 1'b0;
            w_got[p]           = 1'b0;
          end
        end
      end
    end
  end

  task automatic wait_accept(input bit rd, input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge aclk);
      if (rd ? s_arready : (s_awready && s_wready)) begin
        ok = 1'b1;
        break;
      end
    end
    chk(name, ok, 1'b1);
    @(posedge aclk); #1;
  endtask

  // Count cycles after the accept until the upstream response handshake.
  task automatic run_resp();
    lat = 0;
    arv_cycles = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge aclk);
      lat++;
      if (lat == 1) begin
        snap_awv = m_awvalid; snap_arv = m_arvalid;
        snap_awaddr = m_awaddr; snap_araddr = m_araddr;
        snap_wdata = m_wdata; snap_wstrb = m_wstrb; snap_aruser = m_aruser;
      end
      if (m_arvalid != '0) arv_cycles++;
      if ((s_rvalid && s_rready) || (s_bvalid && s_bready)) break;
    end
    @(posedge aclk); #1;
  endtask

  task automatic issue_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    s_awaddr = a; s_wdata = d; s_wstrb = s;
    s_awvalid = 1'b1; s_wvalid = 1'b1;
    wait_accept(1'b0, "wr_accept");
    s_awvalid = 1'b0; s_wvalid = 1'b0;
  endtask

  task automatic issue_read(input logic [31:0] a, input logic [3:0] u);
    s_araddr = a; s_aruser = u; s_arvalid = 1'b1;
    wait_accept(1'b1, "rd_accept");
    s_arvalid = 1'b0;
  endtask

  task automatic check_all_zero(input string name);
    chk(name, {s_awready, s_wready, s_arready, s_bvalid, s_rvalid, s_bresp, s_rresp,
               s_rdata, intr_request, m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready}, '0);
    chk({name, "_data"}, |{m_awaddr, m_wdata, m_wstrb, m_araddr, m_aruser}, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    aresetn = 1'b0;
    s_awvalid = 0; s_wvalid = 0; s_arvalid = 0; s_bready = 1; s_rready = 1;
    s_awaddr = 0; s_wdata = 0; s_wstrb = 0; s_araddr = 0; s_aruser = 0;
    port_en = '1; rd_hold = '0; intr_i = 4'b1000;
    for (int p = 0; p < NP; p++) begin
      rd_val[p] = 32'hC0DE_0000 + 32'(p);
      b_val[p]  = 2'b00;
      port_wr_addr[p] = '0;
      port_wr_data[p] = '0;
    end
    repeat (3) @(negedge aclk);
    check_all_zero("reset_outputs");
    intr_i = '0;
    @(posedge aclk); #1;
    aresetn = 1'b1;
    @(posedge aclk); #1;

    // Port write to port 2, zero-wait.
    push(1'b0, 2'b00, 32'h0);
    issue_write(32'h0000_2010, 32'hA5A5_0001, 4'hF);
    run_resp();
    chk("wr_latency", lat, 3);
    chk("wr_awvalid_c1", snap_awv, 4'b0100);
    chk("wr_awaddr_c1", snap_awaddr, 48'h010 << 24);
    chk("wr_wdata_p2", snap_wdata[95:64], 32'hA5A5_0001);
    chk("wr_wdata_others", {snap_wdata[127:96], snap_wdata[63:0]}, '0);
    chk("wr_wstrb_c1", snap_wstrb, 16'h0F00);
    chk("wr_port2_addr", port_wr_addr[2], 12'h010);
    chk("wr_port2_data", port_wr_data[2], 32'hA5A5_0001);
    chk("wr_no_read", snap_arv, 4'b0000);

    // Zero-wait read from port 3.
    rd_val[3] = 32'h1234_5678;
    push(1'b1, 2'b00, 32'h1234_5678);
    issue_read(32'h0000_3004, 4'h5);
    run_resp();
    chk("rd_latency", lat, 3);
    chk("rd_arvalid_c1", snap_arv, 4'b1000);
    chk("rd_araddr_c1", snap_araddr, 48'h004 << 36);
    chk("rd_aruser_c1", snap_aruser, 16'h5000);

    // Read decode error: window index 4 with four ports.
    push(1'b1, 2'b11, 32'h0);
    issue_read(32'h0000_4000, 4'h0);
    run_resp();
    chk("rd_decerr_latency", lat, 1);
    chk("rd_decerr_no_arvalid", arv_cycles, 0);

    // Write decode error from upper address bits.
    push(1'b0, 2'b11, 32'h0);
    issue_write(32'h0001_0010, 32'h1111_2222, 4'hF);
    run_resp();
    chk("wr_decerr_latency", lat, 1);
    chk("wr_decerr_no_awvalid", snap_awv, 4'b0000);

    // Partial strobe at the top of port 0's window, error response passed through.
    b_val[0] = 2'b10;
    push(1'b0, 2'b10, 32'h0);
    issue_write(32'h0000_0FFC, 32'hDEAD_BEEF, 4'b0011);
    run_resp();
    chk("wr_p0_wstrb", snap_wstrb, 16'h0003);
    chk("wr_p0_addr", port_wr_addr[0], 12'hFFC);
    b_val[0] = 2'b00;

`ifdef MPC_FABRIC_TIMEOUT_EN
    // Port 1 never accepts the read address.
    port_en = 4'b1101;
    push(1'b1, 2'b10, 32'hFFFF_FFFF);
    issue_read(32'h0000_1008, 4'h0);
    run_resp();
    chk("tmo_latency", lat, 12);
    chk("tmo_arvalid_cycles", arv_cycles, 10);
    port_en = '1;
`endif

    // Reset while waiting for read data; the transaction must vanish.
    rd_hold = 4'b0100;
    intr_i  = 4'b0001;
    issue_read(32'h0000_2008, 4'h0);
    @(negedge aclk);
    @(negedge aclk);
    chk("rwait_rready", m_rready, 4'b0100);
    chk("rwait_intr", intr_request, 1'b1);
    #2 aresetn = 1'b0;
    #1 check_all_zero("midreset_outputs");
    intr_i = '0;
    repeat (2) @(posedge aclk);
    #1 aresetn = 1'b1;
    rd_hold = '0;
    @(posedge aclk); #1;

    // Both directions pending twice in a row: write, read, write, read.
    push(1'b0, 2'b00, 32'h0);
    push(1'b1, 2'b00, rd_val[2]);
    push(1'b0, 2'b00, 32'h0);
    push(1'b1, 2'b00, rd_val[3]);
    fork
      begin
        issue_write(32'h0000_0010, 32'h0000_0001, 4'hF);
        issue_write(32'h0000_1020, 32'h0000_0002, 4'hF);
      end
      begin
        issue_read(32'h0000_2000, 4'h1);
        issue_read(32'h0000_3000, 4'h2);
      end
    join
    for (int i = 0; i < 50 && sb_q.size() != 0; i++) @(negedge aclk);
    chk("arb_p1_data", port_wr_data[1], 32'h0000_0002);
    chk("arb_p0_data", port_wr_data[0], 32'h0000_0001);

    // Interrupt follows with one cycle of latency.
    @(posedge aclk); #1;
    intr_i = 4'b0100;
    @(negedge aclk);
    chk("intr_same_cycle", intr_request, 1'b0);
    @(negedge aclk);
    chk("intr_next_cycle", intr_request, 1'b1);

    repeat (4) @(negedge aclk);
    chk("sb_drained", sb_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/mpc_axil_fabric.md
# mpc_axil_fabric

Parametrised AXI4-Lite fabric between the PCI target bridge and the multi-port CAN controller, in the `aclk` domain. It decodes one upstream AXI-Lite slave port into `PORT_NUM` per-port register windows and drives one AXI-Lite master bus per CAN port. Each transaction has a bounded response time. The per-port interrupt lines are combined into a single registered `intr_request`.

## Interface
- `PORT_NUM`, 4: number of CAN ports, 1..16.
- `PORT_ADDR_BITS`, 12: byte-address width of each port window; the port index is `s_awaddr`/`s_araddr` >> `PORT_ADDR_BITS`.
- `TIMEOUT_CYCLES`, 255: downstream cycles allowed before an error response, 2..65535.

Clock and reset:
- `aclk` in 1: single clock.
- `aresetn` in 1: asynchronous, active-low reset.

Upstream (slave):
- `s_awvalid`/`s_awready` in/out 1, `s_awaddr` in 32.
- `s_wvalid`/`s_wready` in/out 1, `s_wdata` in 32, `s_wstrb` in 4.
- `s_bvalid`/`s_bready` out/in 1, `s_bresp` out 2.
- `s_arvalid`/`s_arready` in/out 1, `s_araddr` in 32, `s_aruser` in 4.
- `s_rvalid`/`s_rready` out/in 1, `s_rdata` out 32, `s_rresp` out 2.

Downstream (master, flattened; port p occupies slice p):
- `m_awvalid`/`m_awready` out/in `PORT_NUM`, `m_awaddr` out `PORT_NUM*PORT_ADDR_BITS`.
- `m_wvalid`/`m_wready` out/in `PORT_NUM`, `m_wdata` out `PORT_NUM*32`, `m_wstrb` out `PORT_NUM*4`.
- `m_bvalid`/`m_bready` in/out `PORT_NUM`, `m_bresp` in `PORT_NUM*2`.
- `m_arvalid`/`m_arready` out/in `PORT_NUM`, `m_araddr` out `PORT_NUM*PORT_ADDR_BITS`, `m_aruser` out `PORT_NUM*4`.
- `m_rvalid`/`m_rready` in/out `PORT_NUM`, `m_rdata` in `PORT_NUM*32`, `m_rresp` in `PORT_NUM*2`.

Interrupts:
- `intr_i` in `PORT_NUM`: level interrupt from each port.
- `intr_request` out 1: registered OR of `intr_i`.

## Operation
- One transaction is outstanding at a time.
- **State machine:** IDLE, W_REQ, W_WAIT, W_RESP, R_REQ, R_WAIT, R_RESP.
- **IDLE accept:** `s_awready` and `s_wready` rise together only when `s_awvalid && s_wvalid` and write is granted. `s_arready` rises when `s_arvalid` and read is granted.
- **Arbitration:** with only one of write or read pending, it is granted. When both are pending, the direction not granted last wins. After reset the last grant is read, so write wins first.
- **Capture on accept:** address, data, strobe, `aruser` and port index are registered. Downstream address = upstream address[`PORT_ADDR_BITS`-1:0].
- **Decode error:** port index >= `PORT_NUM` or upper address bits nonzero goes straight to W_RESP/R_RESP with resp 2'b11 (DECERR), `s_rdata` 0, and no downstream activity.
- **W_REQ:** assert `m_awvalid[p]` and `m_wvalid[p]`. Each drops independently on its own handshake. Go to W_WAIT once both have completed.
- **W_WAIT:** `m_bready[p]`=1. On `m_bvalid[p]`, latch `m_bresp` and go to W_RESP.
- **R_REQ:** `m_arvalid[p]` until `m_arready[p]`, then R_WAIT.
- **R_WAIT:** `m_rready[p]`=1. On `m_rvalid[p]`, latch data and resp and go to R_RESP.
- **W_RESP / R_RESP:** hold `s_bvalid`/`s_rvalid` until `s_bready`/`s_rready`, then IDLE.
- Unselected port slices are held at 0 on valid/ready outputs and at 0 on data outputs.
- **Interrupt:** `intr_request` <= |`intr_i` every cycle.

## Timing
- **Reset:** all valid/ready outputs 0, `s_bresp`/`s_rresp` 0, `s_rdata` 0, `intr_request` 0, state IDLE, timer 0.
- **Upstream handshake** occurs in IDLE on cycle 0. Downstream valid is asserted from cycle 1.
- **Zero-wait port read:** `m_arready` in cycle 1, `m_rvalid` in cycle 2, `s_rvalid` in cycle 3. A write follows the same cycles.
- **Decode-error response:** `s_bvalid`/`s_rvalid` asserted in cycle 1.
- **Interrupt latency:** `intr_request` follows `intr_i` with 1 cycle latency.
- **Reset mid-transaction:** reset asserted at any point returns to the reset values immediately. The transaction is lost and no response is issued.
- **Handshake rules:** valid never depends on ready. Upstream ready is asserted only in IDLE.

## Configuration
- **`MPC_FABRIC_TIMEOUT_EN` defined:**
  - A 16-bit timer clears on entry to W_REQ/R_REQ and increments in W_REQ, W_WAIT, R_REQ and R_WAIT.
  - When the timer equals `TIMEOUT_CYCLES`, all downstream valid/ready to port p drop the same cycle and the block enters W_RESP/R_RESP.
  - The timeout response is resp 2'b10 (SLVERR) with `s_rdata` 32'hFFFF_FFFF.
- **Not defined:** no timer logic; the block waits on the downstream port indefinitely.

## Structure
- **Package `mpc_fabric_pkg`:**
  - state enum;
  - resp constants OKAY 2'b00, SLVERR 2'b10, DECERR 2'b11;
  - timeout read fill 32'hFFFF_FFFF.
- **Sub-module `mpc_fabric_timer`:** clear/enable/limit inputs, expired output. It is instantiated only under `MPC_FABRIC_TIMEOUT_EN`.

## Test plan
- **Port write:** write 0x0000_2010 data 0xA5A5_0001 strb 0xF, `PORT_NUM`=4 → port 2 sees awaddr 0x010 and wdata 0xA5A5_0001; `s_bresp` OKAY; other ports idle.
- **Zero-wait read:** read 0x0000_3004 with aruser 0x5 → `m_araddr[3]`=0x004, `m_aruser[3]`=0x5; `m_rdata` 0x1234_5678 returns `s_rdata` 0x1234_5678 with `s_rvalid` at cycle 3.
- **Decode error:** read 0x0000_4000 (`PORT_NUM`=4) → `s_rresp` 2'b11 and `s_rdata` 0 at cycle 1; no downstream valid.
- **Timeout:** `TIMEOUT_CYCLES`=10 and port 1 never asserts `m_arready` → `m_arvalid[1]` drops after 10 cycles; `s_rresp` 2'b10, `s_rdata` 0xFFFF_FFFF.
- **Arbitration:** aw/w and ar valid in the same cycle, twice back-to-back → write granted first, then read, then write.
- **Reset and interrupt:** reset asserted in R_WAIT → all outputs 0 immediately and IDLE after release. Then `intr_i`=4'b0100 → `intr_request`=1 one cycle later.
